// File: rtl/store_narrow.sv
// Store-side narrowing unit: turns a register value, byte address and size into one
// word-aligned big-endian memory write, holds it until ack or timeout, then reports.
module store_narrow #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        done,
  output logic        misalign,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        misal_q, misal_d;
  logic        tout_q, tout_d;

  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic        bad_n;

  // Lane steering of the incoming request; only consumed when a request is accepted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    be_n    = 4'b0000;
    wdata_n = req_data;
    bad_n   = 1'b0;
    unique case (req_size)
      2'b00: begin
        be_n    = 4'b1000 >> req_addr[1:0];
        wdata_n = {4{req_data[7:0]}};
      end
      2'b01: begin
        be_n    = req_addr[1] ? 4'b0011 : 4'b1100;
        wdata_n = {2{req_data[15:0]}};
        bad_n   = req_addr[0];
      end
      2'b10: begin
        be_n  = 4'b1111;
        bad_n = |req_addr[1:0];
      end
      default: bad_n = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    misal_d = misal_q;
    tout_d  = tout_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = {req_addr[31:2], 2'b00};
          wdata_d = wdata_n;
          be_d    = be_n;
          misal_d = bad_n;
          tout_d  = 1'b0;
          cnt_d   = '0;
          state_d = bad_n ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        // An ack on the last allowed cycle still counts as success.
        if (mem_ack) begin
          state_d = FINISH;
        end else if (cnt_q == CNT_LAST) begin
          tout_d  = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      misal_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      misal_q <= misal_d;
      tout_q  <= tout_d;
    end
  end

  // Outputs come from flops or state decode only; nothing from req_* or mem_ack leaks through.
  assign req_ready = (state_q == IDLE);
  assign mem_valid = (state_q == ISSUE);
  assign done      = (state_q == FINISH);
  assign misalign  = done & misal_q;
  assign timeout   = done & tout_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule

// File: tb/tb_store_narrow.sv
// Directed and randomized bench for store_narrow (TIMEOUT=4), checked against a
// behavioural model built from byte-lane arithmetic.
module tb_store_narrow;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        done;
  logic        misalign;
  logic        timeout;

  int vectors = 0;
  int miscompares = 0;

  store_narrow #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .done(done), .misalign(misalign), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: which byte offsets (0 = MSB lane) the access touches, and whether it is legal.
  function automatic int access_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_bad(input logic [31:0] a, input logic [1:0] sz);
    int n = access_bytes(sz);
    if (n == 0) return 1'b1;
    return (a % n) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
    logic [3:0] be = '0;
    int off = int'(a % 4);
    for (int o = off; o < off + access_bytes(sz); o++) be[3 - o] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   return (d % 32'h100) * 32'h0101_0101;
      2'b01:   return (d % 32'h1_0000) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  // ack_dly = ISSUE cycles without ack before the ack cycle; ack_dly >= TO never acks.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input int ack_dly);
    bit         bad = ref_bad(a, sz);
    int         exp_cycles = (ack_dly >= TO) ? TO : ack_dly + 1;
    int         k = 0;
    chk("ready_before", req_ready, 1);
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz;
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = $urandom;
    if (bad) begin
      chk("mis_valid", mem_valid, 0);
      chk("mis_done", done, 1);
      chk("mis_flag", misalign, 1);
      chk("mis_tout", timeout, 0);
    end else begin
      while (mem_valid === 1'b1 && k < TO + 2) begin
        if (k == 0) begin
          chk("addr", mem_addr, {a[31:2], 2'b00});
          chk("wdata", mem_wdata, ref_wdata(d, sz));
          chk("be", mem_be, ref_be(a, sz));
        end
        chk("issue_no_done", done, 0);
        mem_ack = (k == ack_dly);
        @(negedge clk);
        mem_ack = 1'b0;
        k++;
      end
      chk("issue_cycles", k, exp_cycles);
      chk("done", done, 1);
      chk("misalign", misalign, 0);
      chk("timeout", timeout, (ack_dly >= TO) ? 1 : 0);
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", mem_valid, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // SB sweep
    for (int i = 0; i < 4; i++) do_store(32'h100 + i, 32'h1234_56AB, 2'b00, 0);

    // SH / SW
    do_store(32'h202, 32'hFFFF_8001, 2'b01, 0);
    do_store(32'h300, 32'hDEAD_BEEF, 2'b10, 2);

    // Misaligned and reserved size
    do_store(32'h101, 32'h0000_1111, 2'b01, 0);
    do_store(32'h102, 32'h2222_2222, 2'b10, 0);
    do_store(32'h100, 32'h3333_3333, 2'b11, 0);

    // Timeout, then ack on the last allowed cycle
    do_store(32'h400, 32'hCAFE_F00D, 2'b10, TO + 10);
    do_store(32'h404, 32'hCAFE_F00D, 2'b10, TO - 1);

    // Stray ack in IDLE
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_valid", mem_valid, 0);
    chk("stray_done", done, 0);
    chk("stray_ready", req_ready, 1);

    // Reset in the middle of ISSUE
    req_valid = 1'b1; req_addr = 32'h500; req_data = 32'h5555_AAAA; req_size = 2'b10;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_valid", mem_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", req_ready, 1);
    chk("arst_valid", mem_valid, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_wdata", mem_wdata, 0);
    chk("arst_be", mem_be, 0);
    chk("arst_flags", {done, misalign, timeout}, 0);
    @(negedge clk);
    chk("arst_no_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    do_store(32'h504, 32'h0BAD_F00D, 2'b01, 1);

    // req_valid and mem_ack held high: one accept every 3 cycles
    req_valid = 1'b1; req_addr = 32'h600; req_data = 32'h7777_8888; req_size = 2'b10;
    mem_ack = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("b2b_ready", req_ready, (i % 3 == 0) ? 1 : 0);
      chk("b2b_valid", mem_valid, (i % 3 == 1) ? 1 : 0);
      chk("b2b_done", done, (i % 3 == 2) ? 1 : 0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Randomized stores against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra = $urandom;
      logic [31:0] rd = $urandom;
      logic [1:0]  rs = 2'($urandom_range(0, 3));
      do_store(ra, rd, rs, int'($urandom_range(0, TO + 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
